game_countdown_timer: RTL and testbench

//  Consumer of the tenth-second tick produced by the slow-clock counter.

---
 rtl/game_countdown_timer.sv | 127 ++++++++++++
 tb/tb_game_countdown_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Game countdown timer: counts the time limit down in 0.1 s steps as BCD SS.t
// digits, with load/start/pause/bonus controls and warning/timeout flags.
module game_countdown_timer #(
    parameter int MAX_SEC   = 99,
    parameter int BONUS_SEC = 5,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       load,
    input  logic [6:0] load_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       add_bonus,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       warning,
    output logic       expired,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

    localparam logic [7:0] MAX_SEC_B   = 8'(MAX_SEC);
    localparam logic [7:0] BONUS_SEC_B = 8'(BONUS_SEC);
    localparam logic [7:0] WARN_SEC_B  = 8'(WARN_SEC);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tenths_q, tenths_d;
    logic       warning_q, warning_d;
    logic       timeout_q, timeout_d;

    logic [7:0] sec_cur;
    logic [7:0] sec_nxt;
    logic [7:0] sec_bonus;
    logic [7:0] load_clamped;
    logic [3:0] tenths_nxt;
    logic       time_zero;
    logic       do_tick;

    // Whole seconds are handled in binary and re-split into BCD digits on the way out.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        timeout_d    = 1'b0;
        do_tick      = 1'b0;
        sec_cur      = 8'(tens_q) * 8'd10 + 8'(ones_q);
        sec_nxt      = sec_cur;
        sec_bonus    = 8'd0;
        tenths_nxt   = tenths_q;
        time_zero    = (sec_cur == 8'd0) && (tenths_q == 4'd0);
        load_clamped = ({1'b0, load_sec} > MAX_SEC_B) ? MAX_SEC_B : {1'b0, load_sec};

        if (load) begin
            sec_nxt    = load_clamped;
            tenths_nxt = 4'd0;
            state_d    = IDLE;
        end else begin
            if (start) begin
                if ((state_q == IDLE || state_q == PAUSED) && !time_zero)
                    state_d = RUNNING;
            end else if (pause && state_q == RUNNING) begin
                state_d = PAUSED;
            end

            // A tick counts only when the timer is running and stays running this cycle.
            do_tick = tick && (state_q == RUNNING) && (state_d == RUNNING);
            if (do_tick) begin
                if (tenths_q != 4'd0) begin
                    tenths_nxt = tenths_q - 4'd1;
                end else if (sec_cur != 8'd0) begin
                    tenths_nxt = 4'd9;
                    sec_nxt    = sec_cur - 8'd1;
                end
            end

            if (add_bonus && state_q != EXPIRED) begin
                sec_bonus = sec_nxt + BONUS_SEC_B;
                sec_nxt   = (sec_bonus > MAX_SEC_B) ? MAX_SEC_B : sec_bonus;
            end

            if (do_tick && sec_nxt == 8'd0 && tenths_nxt == 4'd0) begin
                state_d   = EXPIRED;
                timeout_d = 1'b1;
            end
        end

        tens_d    = 4'(sec_nxt / 8'd10);
        ones_d    = 4'(sec_nxt % 8'd10);
        tenths_d  = tenths_nxt;
        warning_d = (state_d != EXPIRED) && (sec_nxt < WARN_SEC_B) &&
                    ((sec_nxt != 8'd0) || (tenths_nxt != 4'd0));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            tenths_q  <= 4'd0;
            warning_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            tenths_q  <= tenths_d;
            warning_q <= warning_d;
            timeout_q <= timeout_d;
        end
    end

    assign sec_tens      = tens_q;
    assign sec_ones      = ones_q;
    assign tenths        = tenths_q;
    assign running       = (state_q == RUNNING);
    assign expired       = (state_q == EXPIRED);
    assign warning       = warning_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: time kept as an integer count of tenths in a
// behavioural model, compared against the DUT on every falling edge.
module tb_game_countdown_timer;

    localparam int MAX_SEC   = 99;
    localparam int BONUS_SEC = 5;
    localparam int WARN_SEC  = 10;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, add_bonus = 1'b0;
    logic [6:0] load_sec = 7'd0;
    logic [3:0] sec_tens, sec_ones, tenths;
    logic       running, warning, expired, timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model: remaining time in tenths of a second, plus a coarse state code.
    int m_time  = 0;
    int m_state = M_IDLE;
    int m_pulse = 0;

    game_countdown_timer #(
        .MAX_SEC(MAX_SEC), .BONUS_SEC(BONUS_SEC), .WARN_SEC(WARN_SEC)
    ) dut (
        .clk(clk), .resetN(resetN), .tick(tick), .load(load), .load_sec(load_sec),
        .start(start), .pause(pause), .add_bonus(add_bonus),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .tenths(tenths),
        .running(running), .warning(warning), .expired(expired),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_digits();
        return ((m_time / 100) << 8) | (((m_time / 10) % 10) << 4) | (m_time % 10);
    endfunction

    function automatic int model_warning();
        return (m_state != M_EXP && m_time < WARN_SEC * 10 && m_time != 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] dut_digits();
        return {20'd0, sec_tens, sec_ones, tenths};
    endfunction

    task automatic model_reset();
        m_time  = 0;
        m_state = M_IDLE;
        m_pulse = 0;
    endtask

    task automatic model_update(input bit l, input int ls, input bit s, input bit p,
                                input bit t, input bit b);
        int nst;
        int sec;
        bit ticked;
        m_pulse = 0;
        if (l) begin
            m_time  = ((ls > MAX_SEC) ? MAX_SEC : ls) * 10;
            m_state = M_IDLE;
            return;
        end
        nst = m_state;
        if (s) begin
            if ((m_state == M_IDLE || m_state == M_PAUSE) && m_time != 0) nst = M_RUN;
        end else if (p && m_state == M_RUN) begin
            nst = M_PAUSE;
        end
        ticked = t && m_state == M_RUN && nst == M_RUN;
        if (ticked && m_time > 0) m_time = m_time - 1;
        if (b && m_state != M_EXP) begin
            sec    = m_time / 10 + BONUS_SEC;
            if (sec > MAX_SEC) sec = MAX_SEC;
            m_time = sec * 10 + m_time % 10;
        end
        if (ticked && m_time == 0) begin
            nst     = M_EXP;
            m_pulse = 1;
        end
        m_state = nst;
    endtask

    // Drive one cycle of inputs, let the DUT sample them, and advance the model.
    task automatic step(input bit l, input int ls, input bit s, input bit p,
                        input bit t, input bit b);
        load = l; load_sec = 7'(ls); start = s; pause = p; tick = t; add_bonus = b;
        @(posedge clk);
        model_update(l, ls, s, p, t, b);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; add_bonus = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("digits",  dut_digits(), m_time >= 0 ? model_digits() : 0);
            check("running", 32'(running), (m_state == M_RUN) ? 1 : 0);
            check("expired", 32'(expired), (m_state == M_EXP) ? 1 : 0);
            check("warning", 32'(warning), model_warning());
            check("timeout", 32'(timeout_pulse), m_pulse);
        end
    end

    initial begin
        #2;
        check("reset_digits", dut_digits(), 0);
        check("reset_flags", {28'd0, running, warning, expired, timeout_pulse}, 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        cmp_en = 1'b1;

        // Countdown from 3 s to expiry.
        step(1, 3, 0, 0, 0, 0);
        check("t1_load", dut_digits(), 32'h030);
        step(0, 0, 1, 0, 0, 0);
        ticks(1);
        check("t1_first_tick", dut_digits(), 32'h029);
        ticks(28);
        check("t1_last_tenth", dut_digits(), 32'h001);
        ticks(1);
        check("t1_zero", dut_digits(), 32'h000);
        check("t1_pulse", 32'(timeout_pulse), 1);
        check("t1_expired", 32'(expired), 1);
        ticks(3);
        check("t1_hold", dut_digits(), 32'h000);
        check("t1_pulse_once", 32'(timeout_pulse), 0);

        // Double borrow and warning onset.
        step(1, 10, 0, 0, 0, 0);
        check("t2_no_warn", 32'(warning), 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(1);
        check("t2_borrow", dut_digits(), 32'h099);
        check("t2_warn", 32'(warning), 1);

        // Pause holds the time.
        step(1, 6, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(10);
        check("t3_at5", dut_digits(), 32'h050);
        step(0, 0, 0, 1, 0, 0);
        ticks(20);
        check("t3_paused", dut_digits(), 32'h050);
        step(0, 0, 1, 0, 0, 0);
        ticks(1);
        check("t3_resume", dut_digits(), 32'h049);

        // Bonus saturation and tick+bonus at 00.1.
        step(1, 97, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("t4_sat", dut_digits(), 32'h990);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(9);
        check("t4_at01", dut_digits(), 32'h001);
        step(0, 0, 0, 0, 1, 1);
        check("t4_rescue", dut_digits(), 32'h050);
        check("t4_no_pulse", {30'd0, timeout_pulse, running}, 1);

        // Load clamp, start refused at zero.
        step(1, 120, 0, 0, 0, 0);
        check("t5_clamp", dut_digits(), 32'h990);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("t5_no_start", 32'(running), 0);

        // Load beats tick while running; then asynchronous reset mid-count.
        step(1, 43, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(7);
        check("t6_at423", dut_digits(), 32'h423);
        step(1, 7, 0, 0, 1, 0);
        check("t6_load", dut_digits(), 32'h070);
        check("t6_idle", 32'(running), 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(3);
        #2 resetN = 1'b0;
        model_reset();
        #1;
        check("t6_rst_digits", dut_digits(), 0);
        check("t6_rst_flags", {28'd0, running, warning, expired, timeout_pulse}, 0);
        @(posedge clk);
        #1 resetN = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit l, s, p, t, b;
            int ls;
            l  = ($urandom_range(0, 99) < 3);
            ls = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 127));
            s  = ($urandom_range(0, 99) < 10);
            p  = ($urandom_range(0, 99) < 5);
            t  = ($urandom_range(0, 99) < 60);
            b  = ($urandom_range(0, 99) < 3);
            step(l, ls, s, p, t, b);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
